// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider answering the ALU controller's
// start_div / div_done handshake. One quotient bit is produced per clock;
// signed operation divides magnitudes and fixes the signs in a final cycle.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_div,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_done,
  output logic             busy,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_r;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH:0]     rem_r;        // partial remainder, one bit wider than operands
  logic [WIDTH-1:0]   dq_r;         // dividend bits shift out of the top, quotient bits in at the bottom
  logic [WIDTH-1:0]   dvsr_r;       // divisor magnitude
  logic [WIDTH-1:0]   dvnd_orig_r;  // raw dividend, needed for divide-by-zero and overflow
  logic               sign_a_r;
  logic               sign_b_r;
  logic               smode_r;
  logic               zero_r;

  logic [WIDTH-1:0]   dvnd_mag_s;
  logic [WIDTH-1:0]   dvsr_mag_s;
  logic [WIDTH:0]     trial_s;
  logic [WIDTH:0]     diff_s;
  logic               ge_s;
  logic [WIDTH-1:0]   fix_q_s;
  logic [WIDTH-1:0]   fix_r_s;
  logic               ovf_s;

  // Operand magnitudes; the most-negative value maps to its unsigned magnitude.
  always_comb begin
    if (signed_mode && dividend[WIDTH-1]) begin
      dvnd_mag_s = ZERO_W - dividend;
    end else begin
      dvnd_mag_s = dividend;
    end
    if (signed_mode && divisor[WIDTH-1]) begin
      dvsr_mag_s = ZERO_W - divisor;
    end else begin
      dvsr_mag_s = divisor;
    end
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    trial_s = {rem_r[WIDTH-1:0], dq_r[WIDTH-1]};
    if (trial_s >= {1'b0, dvsr_r}) begin
      ge_s   = 1'b1;
      diff_s = trial_s - {1'b0, dvsr_r};
    end else begin
      ge_s   = 1'b0;
      diff_s = trial_s;
    end
  end

  // Final result with sign correction and special cases.
  always_comb begin
    if (zero_r) begin
      fix_q_s = ONES_W;
      fix_r_s = dvnd_orig_r;
    end else begin
      if (sign_a_r ^ sign_b_r) begin
        fix_q_s = ZERO_W - dq_r;
      end else begin
        fix_q_s = dq_r;
      end
      if (sign_a_r) begin
        fix_r_s = ZERO_W - rem_r[WIDTH-1:0];
      end else begin
        fix_r_s = rem_r[WIDTH-1:0];
      end
    end
    ovf_s = smode_r & ~zero_r & (dvnd_orig_r == MOST_NEG) & sign_b_r & (dvsr_r == ONE_W);
  end

  // Control FSM with the working registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      rem_r       <= {(WIDTH+1){1'b0}};
      dq_r        <= ZERO_W;
      dvsr_r      <= ZERO_W;
      dvnd_orig_r <= ZERO_W;
      sign_a_r    <= 1'b0;
      sign_b_r    <= 1'b0;
      smode_r     <= 1'b0;
      zero_r      <= 1'b0;
      quotient    <= ZERO_W;
      remainder   <= ZERO_W;
      div_done    <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      div_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_div) begin
            rem_r       <= {(WIDTH+1){1'b0}};
            dq_r        <= dvnd_mag_s;
            dvsr_r      <= dvsr_mag_s;
            dvnd_orig_r <= dividend;
            sign_a_r    <= signed_mode & dividend[WIDTH-1];
            sign_b_r    <= signed_mode & divisor[WIDTH-1];
            smode_r     <= signed_mode;
            zero_r      <= (divisor == ZERO_W);
            cnt_r       <= CNT_INIT;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            if (divisor == ZERO_W) begin
              state_r <= FIX;
            end else begin
              state_r <= CALC;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          rem_r <= diff_s;
          dq_r  <= {dq_r[WIDTH-2:0], ge_s};
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r <= FIX;
          end else begin
            state_r <= CALC;
          end
        end
        FIX: begin
          quotient    <= fix_q_s;
          remainder   <= fix_r_s;
          div_by_zero <= zero_r;
          overflow    <= ovf_s;
          div_done    <= 1'b1;
          busy        <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8): directed cases plus random
// operands checked against an integer-arithmetic reference model.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_div;
  logic         signed_mode;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_done;
  logic         busy;
  logic         div_by_zero;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start_div(start_div), .signed_mode(signed_mode),
    .dividend(dividend), .divisor(divisor), .quotient(quotient),
    .remainder(remainder), .div_done(div_done), .busy(busy),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division, truncating toward zero.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dbz, output logic ovf);
    int sa, sb, iq, ir;
    dbz = 1'b0;
    ovf = 1'b0;
    if (b == 8'h00) begin
      q = 8'hFF; r = a; dbz = 1'b1;
    end else if (!sm) begin
      iq = int'(a) / int'(b);
      ir = int'(a) % int'(b);
      q = iq[W-1:0]; r = ir[W-1:0];
    end else begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sa == -128 && sb == -1) begin
        q = 8'h80; r = 8'h00; ovf = 1'b1;
      end else begin
        iq = sa / sb;
        ir = sa % sb;
        q = iq[W-1:0]; r = ir[W-1:0];
      end
    end
  endfunction

  // Issue one divide and collect what the DUT returned (bounded wait).
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic dbz, output logic ovf,
                        output int lat, output int busy_bad, output logic done_next);
    @(negedge clk);
    dividend = a; divisor = b; signed_mode = sm; start_div = 1'b1;
    @(posedge clk); #1;
    start_div = 1'b0;
    busy_bad = (busy !== 1'b1) ? 1 : 0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (div_done === 1'b1) break;
      if (busy !== 1'b1) busy_bad++;
    end
    if (busy !== 1'b0) busy_bad++;
    q = quotient; r = remainder; dbz = div_by_zero; ovf = overflow;
    @(posedge clk); #1;
    done_next = div_done;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_div = 1'b0; signed_mode = 1'b0; dividend = 8'h00; divisor = 8'h00;
    #12;
    checks++;
    if ({quotient, remainder, div_done, busy, div_by_zero, overflow} !== 20'h00000) begin
      errors++;
      $display("FAIL reset_state: got q=%h r=%h done=%b busy=%b dbz=%b ovf=%b, want all 0",
               quotient, remainder, div_done, busy, div_by_zero, overflow);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_unsigned();
    logic [W-1:0] q, r; logic dbz, ovf, dn; int lat, bb;
    do_div(8'hC8, 8'h07, 1'b0, q, r, dbz, ovf, lat, bb, dn);
    checks++;
    if ({q, r, dbz, ovf} !== {8'h1C, 8'h04, 1'b0, 1'b0}) begin
      errors++; $display("FAIL unsigned_c8_07: got %h/%h dbz=%b ovf=%b, want 1c/04 0 0", q, r, dbz, ovf);
    end
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL unsigned_latency: got %0d, want 9", lat); end
    checks++;
    if (bb !== 0) begin errors++; $display("FAIL unsigned_busy: %0d bad busy samples, want 0", bb); end
    checks++;
    if (dn !== 1'b0) begin errors++; $display("FAIL done_one_cycle: done=%b next cycle, want 0", dn); end
  endtask

  task automatic test_signed();
    logic [W-1:0] q, r; logic dbz, ovf, dn; int lat, bb;
    do_div(8'hF9, 8'h02, 1'b1, q, r, dbz, ovf, lat, bb, dn);
    checks++;
    if ({q, r, dbz, ovf} !== {8'hFD, 8'hFF, 1'b0, 1'b0}) begin
      errors++; $display("FAIL signed_m7_2: got %h/%h dbz=%b ovf=%b, want fd/ff 0 0", q, r, dbz, ovf);
    end
    do_div(8'h07, 8'hFE, 1'b1, q, r, dbz, ovf, lat, bb, dn);
    checks++;
    if ({q, r, dbz, ovf} !== {8'hFD, 8'h01, 1'b0, 1'b0}) begin
      errors++; $display("FAIL signed_7_m2: got %h/%h dbz=%b ovf=%b, want fd/01 0 0", q, r, dbz, ovf);
    end
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL signed_latency: got %0d, want 9", lat); end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] q, r; logic dbz, ovf, dn; int lat, bb;
    for (int m = 0; m < 2; m++) begin
      do_div(8'h55, 8'h00, m[0], q, r, dbz, ovf, lat, bb, dn);
      checks++;
      if ({q, r, dbz, ovf} !== {8'hFF, 8'h55, 1'b1, 1'b0}) begin
        errors++; $display("FAIL div_zero_mode%0d: got %h/%h dbz=%b ovf=%b, want ff/55 1 0", m, q, r, dbz, ovf);
      end
      checks++;
      if (lat !== 1 || bb !== 0 || dn !== 1'b0) begin
        errors++; $display("FAIL div_zero_timing_mode%0d: lat=%0d busybad=%0d donenext=%b, want 1/0/0", m, lat, bb, dn);
      end
    end
    do_div(8'h09, 8'h03, 1'b0, q, r, dbz, ovf, lat, bb, dn);
    checks++;
    if ({q, r, dbz} !== {8'h03, 8'h00, 1'b0}) begin
      errors++; $display("FAIL div_zero_clear: got %h/%h dbz=%b, want 03/00 0", q, r, dbz);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] q, r; logic dbz, ovf, dn; int lat, bb;
    do_div(8'h80, 8'hFF, 1'b1, q, r, dbz, ovf, lat, bb, dn);
    checks++;
    if ({q, r, dbz, ovf} !== {8'h80, 8'h00, 1'b0, 1'b1}) begin
      errors++; $display("FAIL overflow_signed: got %h/%h dbz=%b ovf=%b, want 80/00 0 1", q, r, dbz, ovf);
    end
    do_div(8'h80, 8'hFF, 1'b0, q, r, dbz, ovf, lat, bb, dn);
    checks++;
    if ({q, r, dbz, ovf} !== {8'h00, 8'h80, 1'b0, 1'b0}) begin
      errors++; $display("FAIL overflow_unsigned: got %h/%h dbz=%b ovf=%b, want 00/80 0 0", q, r, dbz, ovf);
    end
  endtask

  task automatic test_ignored_start();
    logic [W-1:0] q, r; logic dbz, ovf, dn; int lat, bb;
    @(negedge clk);
    dividend = 8'hC8; divisor = 8'h07; signed_mode = 1'b0; start_div = 1'b1;
    @(posedge clk); #1;
    start_div = 1'b0;
    lat = 0;
    repeat (3) begin @(posedge clk); #1; lat++; end
    dividend = 8'h10; divisor = 8'h02; start_div = 1'b1;
    @(posedge clk); #1;
    lat++;
    start_div = 1'b0;
    while (lat < 40 && div_done !== 1'b1) begin @(posedge clk); #1; lat++; end
    checks++;
    if ({quotient, remainder} !== {8'h1C, 8'h04} || lat !== 9) begin
      errors++; $display("FAIL ignored_start: got %h/%h lat=%0d, want 1c/04 lat=9", quotient, remainder, lat);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({quotient, remainder, busy} !== {8'h1C, 8'h04, 1'b0}) begin
      errors++; $display("FAIL result_hold: got %h/%h busy=%b, want 1c/04 0", quotient, remainder, busy);
    end
    do_div(8'h10, 8'h02, 1'b0, q, r, dbz, ovf, lat, bb, dn);
    checks++;
    if ({q, r} !== {8'h08, 8'h00} || lat !== 9) begin
      errors++; $display("FAIL after_ignored: got %h/%h lat=%0d, want 08/00 lat=9", q, r, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] q, r; logic dbz, ovf, dn; int lat, bb, seen;
    do_div(8'hC8, 8'h07, 1'b0, q, r, dbz, ovf, lat, bb, dn);
    @(negedge clk);
    dividend = 8'hF9; divisor = 8'h02; signed_mode = 1'b1; start_div = 1'b1;
    @(posedge clk); #1;
    start_div = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({quotient, remainder, div_done, busy, div_by_zero, overflow} !== 20'h00000) begin
      errors++;
      $display("FAIL reset_mid: got q=%h r=%h done=%b busy=%b dbz=%b ovf=%b, want all 0",
               quotient, remainder, div_done, busy, div_by_zero, overflow);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (12) begin @(posedge clk); #1; if (div_done === 1'b1) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL reset_no_done: got %0d done pulses, want 0", seen); end
    do_div(8'h10, 8'h02, 1'b0, q, r, dbz, ovf, lat, bb, dn);
    checks++;
    if ({q, r} !== {8'h08, 8'h00} || lat !== 9) begin
      errors++; $display("FAIL after_reset: got %h/%h lat=%0d, want 08/00 lat=9", q, r, lat);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, q, r, eq, er; logic sm, dbz, ovf, edbz, eovf, dn; int lat, bb, elat;
    for (int i = 0; i < 150; i++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      sm = 1'($urandom_range(0, 1));
      if ((i % 17) == 0) b = 8'h00;
      if ((i % 23) == 5) begin a = 8'h80; b = 8'hFF; end
      ref_div(a, b, sm, eq, er, edbz, eovf);
      elat = (b == 8'h00) ? 1 : 9;
      do_div(a, b, sm, q, r, dbz, ovf, lat, bb, dn);
      checks++;
      if ({q, r, dbz, ovf} !== {eq, er, edbz, eovf} || lat !== elat || bb !== 0 || dn !== 1'b0) begin
        errors++;
        $display("FAIL random_%0d: %h/%h sm=%b got %h/%h dbz=%b ovf=%b lat=%0d busybad=%0d donenext=%b, want %h/%h dbz=%b ovf=%b lat=%0d",
                 i, a, b, sm, q, r, dbz, ovf, lat, bb, dn, eq, er, edbz, eovf, elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle restoring divider: the responder end of the ALU controller's start_div / div_done handshake.
- Samples operands on a one-cycle start pulse and iterates one quotient bit per clock.
- Returns quotient and remainder with a single-cycle done pulse.
- Sits beside the multiplier in the ALU datapath. Its outputs feed the result mux that the controller loads into the output register.

Parameters:
- WIDTH, 8, operand/result width in bits (must be >= 2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_div  in  1  one-cycle request; operands sampled on the same edge.
- signed_mode  in  1  1 = two's-complement divide, 0 = unsigned; sampled with start_div.
- dividend  in  WIDTH  numerator.
- divisor  in  WIDTH  denominator.
- quotient  out  WIDTH  registered result, held until the next accepted start.
- remainder  out  WIDTH  registered result, held until the next accepted start.
- div_done  out  1  single-cycle completion pulse.
- busy  out  1  high from the accepting edge until the edge that raises div_done.
- div_by_zero  out  1  sticky per-operation flag, valid with div_done.
- overflow  out  1  signed most-negative / -1 flag, valid with div_done.

Behaviour:
- Reset: single clock, asynchronous active-high reset (clk, reset).
  - Asserting reset forces state=IDLE and zeroes all outputs, iteration counter and internal registers immediately.
  - This applies mid-operation: the in-flight divide is abandoned and no div_done is produced.
- States: IDLE, CALC, FIX.
- IDLE:
  - start_div=1 at edge E0 latches |dividend|, |divisor| (magnitudes only when signed_mode=1), the sign bits and signed_mode.
  - The same edge clears div_done, div_by_zero and overflow, and sets busy=1.
  - divisor==0: go directly to FIX with the zero flag set internally. Otherwise go to CALC with counter=WIDTH.
- CALC: one restoring step per edge.
  - partial remainder R (WIDTH+1 bits) = {R, next dividend MSB}.
  - If R >= divisor: R -= divisor and shift in quotient bit 1; else shift in 0.
  - Counter decrements. After the WIDTH-th step (edge E_WIDTH), go to FIX.
- FIX: one edge (E_WIDTH+1) writes quotient/remainder/flags, pulses div_done=1, clears busy, returns to IDLE.
  - Sign correction when signed: quotient negated if the operand signs differ; remainder takes the dividend's sign; truncation toward zero.
  - Divide by zero (either mode): quotient = all ones, remainder = original dividend, div_by_zero=1.
  - Signed most-negative / -1: quotient = most-negative value (wraps), remainder = 0, overflow=1.
- div_done: high for exactly one cycle, cleared on the following edge.
- Latency from the accepting edge E0 to div_done high:
  - WIDTH+1 edges normally (9 for WIDTH=8).
  - 1 edge for divide by zero.
- start_div while busy=1 is ignored: no operand resample, no state change.
- start_div on the same edge that raises div_done is also ignored (busy still high). The controller never issues it there.
- quotient/remainder change only in FIX. Between operations they hold the last result, including across ignored starts.
- Width rules:
  - Magnitude of the most-negative value is represented unsigned in WIDTH bits.
  - Internal subtract is WIDTH+1 bits wide so the compare never wraps.

Test Plan:
- Unsigned 0xC8 / 0x07, signed_mode=0 -> quotient 0x1C, remainder 0x04, div_done one cycle high exactly 9 edges after start, busy high for those 9 cycles, flags 0.
- Signed 0xF9(-7) / 0x02 -> quotient 0xFD(-3), remainder 0xFF(-1). Repeat 0x07 / 0xFE -> quotient 0xFD, remainder 0x01.
- 0x55 / 0x00 (both modes) -> quotient 0xFF, remainder 0x55, div_by_zero=1, div_done 1 edge after start. The next valid divide clears the flag.
- Signed 0x80 / 0xFF -> quotient 0x80, remainder 0x00, overflow=1. The same operands unsigned give quotient 0x00, remainder 0x80, overflow=0.
- Start 0xC8/0x07, pulse start_div again with 0x10/0x02 at cycle 4 -> second pulse ignored, result 0x1C/0x04 at cycle 9. A new start after done gives 0x08/0x00.
- Assert reset at cycle 5 of a divide -> all outputs 0 immediately, no div_done. A start after reset release completes normally.
